alu_seq_exec: RTL
=================

Name: alu_seq_exec

Overview:
- Execute-stage ALU that consumes the 4-bit ALU operation code produced by the ALU-control decoder, together with two 32-bit operands.
- Produces a registered 32-bit result plus branch flags.
- Add, sub, logic, compare and pass complete in one cycle.
- Shifts use an iterative 1-bit-per-cycle shifter to save FPGA area.
- Valid/ready handshakes on both sides let the hazard/stall logic throttle the pipeline.

Parameters:
- XLEN, 32, operand and result width; shift amount is b[4:0].
- CNT_W, 5, shift counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of the in-flight op (branch mispredict / trap).
- in_valid  in  1  operands and op presented.
- in_ready  out  1  unit can accept this cycle.
- alu_op  in  4  ALU operation code from the shared defines (`ALU_*).
- a  in  XLEN  operand A (rs1).
- b  in  XLEN  operand B (rs2 or immediate).
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  registered result.
- zf, cf, vf, sf  out  1 each  zero, carry, overflow, sign flags, registered with result.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset: state=IDLE; out_valid=0; result=0; zf=cf=vf=sf=0; counter=0; in_ready=1 once rst deasserts.
- States:
  - IDLE: empty.
  - SHIFT: iterating.
  - DONE: result held.
- Handshake:
  - Accept when in_valid & in_ready.
  - in_ready = ~flush & (IDLE | (DONE & out_ready)).
  - Inputs are sampled only on accept and need not be held afterwards.
- Transitions:
  - Accept, non-shift op (or shift with b[4:0]==0): -> DONE next edge; result computed combinationally from sampled operands.
  - Accept, shift with shamt n>0: load acc=a, cnt=n -> SHIFT.
  - SHIFT: each edge shifts acc by 1 (SLL: left, zero fill; SRL: right, zero fill; SRA: right, sign fill) and decrements cnt. When cnt reaches 0 -> DONE.
  - Latency: non-shift = 1 cycle, shift = 1+n cycles from the accept cycle to the out_valid cycle.
  - DONE: out_valid=1; result and flags stable until out_ready. With out_ready & ~in_valid -> IDLE. With out_ready & in_valid -> accept back-to-back, no bubble.
- Ops:
  - ADD: a+b. SUB: a-b. AND, OR, XOR: bitwise.
  - SLT: {31'b0, signed a<b}. SLTU: {31'b0, unsigned a<b}.
  - PASS: b.
  - Undefined codes behave as PASS.
- Flags:
  - zf = (result==0) for every op.
  - ADD: cf = carry-out of a+b; vf = signed overflow; sf = result[31].
  - SUB: computed as a + ~b + 1; cf = carry-out (1 means no borrow, a>=b unsigned); vf = (a[31]!=b[31]) & (result[31]!=a[31]); sf = result[31].
  - All other ops: cf=vf=0; sf = result[31].
- flush:
  - Any state -> IDLE on the next edge; out_valid=0; counter cleared.
  - result/flags hold their old values but are invalid.
  - flush wins over a simultaneous in_valid; nothing is accepted.
- Reset mid-operation: async return to the reset values above; the partial shift is discarded.
- Arithmetic is modulo 2^XLEN; wrap-around is silent and reported only via cf/vf.

Optional Feature:
- Macro: ALU_FAST_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter, the SHIFT state is unused, and every op has 1-cycle latency.
- Undefined: iterative shifter as specified.
- Flags and handshake are identical in both builds.

Decomposition:
- Shared defines.v: `ALU_* op codes (already shared with the ALU-control decoder), plus new state encodings `EXS_IDLE, `EXS_SHIFT, `EXS_DONE.
- One natural combinational sub-module: alu_comb_core.
  - Computes result and flags for all non-shift ops (and barrel shifts under ALU_FAST_SHIFT_EN).
  - alu_seq_exec keeps the FSM, counter and output registers.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> next cycle out_valid; result=0x80000000; vf=1, sf=1, cf=0, zf=0.
- SUB a=5, b=5 -> result=0, zf=1, cf=1. SUB a=3, b=5 -> result=0xFFFFFFFE, cf=0, sf=1.
- SRA a=0x80000000, b=4 -> out_valid exactly 5 cycles after the accept cycle (1 cycle with ALU_FAST_SHIFT_EN); result=0xF8000000; in_ready low during SHIFT.
- SLL with b=0x20 (shamt 0) -> 1-cycle latency, result=a. Back-to-back ADD,XOR with out_ready=1 -> two consecutive out_valid cycles, no bubble. out_ready=0 for 3 cycles -> result held, in_ready=0.
- flush asserted on cycle 2 of SLL b=10 with in_valid=1 -> IDLE next edge, out_valid never rises, op not accepted. rst pulsed mid-shift -> all outputs 0 immediately.
- Undefined op 4'b1110, b=0x1234 -> result=0x1234, cf=vf=0.

Source files
------------

// File: rtl/alu_seq_exec_pkg.sv
// alu_seq_exec_pkg: shared widths, ALU op codes, execute-FSM state encodings,
// flag payload type and small helpers used by alu_seq_exec and alu_comb_core.
package alu_seq_exec_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned OP_W  = 4;

  // ALU op codes, common with the ALU-control decoder
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'b0111;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'b1001;
  localparam logic [OP_W-1:0] ALU_PASS = 4'b1010;

  // Execute-stage FSM encodings
  localparam logic [1:0] EXS_IDLE  = 2'd0;
  localparam logic [1:0] EXS_SHIFT = 2'd1;
  localparam logic [1:0] EXS_DONE  = 2'd2;

  typedef struct packed {
    logic zf;
    logic cf;
    logic vf;
    logic sf;
  } alu_flags_t;

  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  // One step of the iterative shifter; op is always one of the shift codes.
  function automatic logic [XLEN-1:0] shift_one(input logic [OP_W-1:0] op,
                                                input logic [XLEN-1:0] v);
    case (op)
      ALU_SLL: return {v[XLEN-2:0], 1'b0};
      ALU_SRL: return {1'b0, v[XLEN-1:1]};
      default: return {v[XLEN-1], v[XLEN-1:1]};
    endcase
  endfunction

  // Flags for ops without carry/overflow semantics
  function automatic alu_flags_t plain_flags(input logic [XLEN-1:0] v);
    alu_flags_t f;
    f.zf = (v == '0);
    f.cf = 1'b0;
    f.vf = 1'b0;
    f.sf = v[XLEN-1];
    return f;
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: single-cycle result and flag computation.
// Ports: op (ALU op code), a/b (operands) -> result, flags {zf,cf,vf,sf}.
// With ALU_FAST_SHIFT_EN defined, shifts are done here by a barrel shifter;
// otherwise shift codes return a, which is the correct shift-by-zero result
// (non-zero shift amounts are handled by the iterative shifter in the top).
module alu_comb_core
  import alu_seq_exec_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output alu_flags_t      flags
);

  logic [XLEN:0] sum;
  logic [XLEN:0] diff;

  // Result and flag mux; undefined codes fall through to PASS
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
    result = b;
    flags  = '0;
    case (op)
      ALU_ADD: begin
        result   = sum[XLEN-1:0];
        flags.cf = sum[XLEN];
        flags.vf = (a[XLEN-1] == b[XLEN-1]) & (sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_SUB: begin
        result   = diff[XLEN-1:0];
        flags.cf = diff[XLEN];
        flags.vf = (a[XLEN-1] != b[XLEN-1]) & (diff[XLEN-1] != a[XLEN-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: result = XLEN'(a < b);
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL:  result = a << b[CNT_W-1:0];
      ALU_SRL:  result = a >> b[CNT_W-1:0];
      ALU_SRA:  result = XLEN'($signed(a) >>> b[CNT_W-1:0]);
`else
      ALU_SLL, ALU_SRL, ALU_SRA: result = a;
`endif
      default:  result = b;
    endcase
    flags.zf = (result == '0);
    flags.sf = result[XLEN-1];
  end

endmodule

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execute-stage ALU with valid/ready on both sides.
// Ports: clk, rst (async active-high), flush (sync abort), in_valid/in_ready,
// alu_op, a, b (input side); out_valid/out_ready, result, zf/cf/vf/sf
// (registered output side).
// Build option ALU_FAST_SHIFT_EN: single-cycle barrel shifts, SHIFT state
// never entered. Default: 1-bit-per-cycle iterative shifter.
module alu_seq_exec
  import alu_seq_exec_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zf,
  output logic            cf,
  output logic            vf,
  output logic            sf
);

  logic [1:0]       state, state_n;
  logic [XLEN-1:0]  acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [OP_W-1:0]  sop, sop_n;
  logic [XLEN-1:0]  result_n;
  alu_flags_t       flags_q, flags_n;
  logic             out_valid_n;

  logic [XLEN-1:0]  core_result;
  alu_flags_t       core_flags;
  logic             accept;
  logic             start_shift;
  logic [XLEN-1:0]  acc_step;

  alu_comb_core u_core (
    .op     (alu_op),
    .a      (a),
    .b      (b),
    .result (core_result),
    .flags  (core_flags)
  );

  // Ready is held low during reset so nothing is taken before rst deasserts
  assign in_ready = ~rst & ~flush &
                    ((state == EXS_IDLE) | ((state == EXS_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

`ifdef ALU_FAST_SHIFT_EN
  assign start_shift = 1'b0;
`else
  assign start_shift = is_shift(alu_op) & (b[CNT_W-1:0] != '0);
`endif

  assign acc_step = shift_one(sop, acc);

  // Next-state and output-register logic
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    sop_n       = sop;
    result_n    = result;
    flags_n     = flags_q;
    out_valid_n = out_valid;
    if (flush) begin
      state_n     = EXS_IDLE;
      cnt_n       = '0;
      out_valid_n = 1'b0;
    end else begin
      case (state)
        EXS_SHIFT: begin
          acc_n = acc_step;
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_n     = EXS_DONE;
            out_valid_n = 1'b1;
            result_n    = acc_step;
            flags_n     = plain_flags(acc_step);
          end
        end
        default: begin
          // IDLE, consumed DONE, or an illegal encoding all drop to IDLE
          if ((state != EXS_DONE) || out_ready) begin
            state_n     = EXS_IDLE;
            out_valid_n = 1'b0;
          end
          if (accept) begin
            if (start_shift) begin
              state_n     = EXS_SHIFT;
              acc_n       = a;
              cnt_n       = b[CNT_W-1:0];
              sop_n       = alu_op;
              out_valid_n = 1'b0;
            end else begin
              state_n     = EXS_DONE;
              result_n    = core_result;
              flags_n     = core_flags;
              out_valid_n = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EXS_IDLE;
      acc       <= '0;
      cnt       <= '0;
      sop       <= '0;
      result    <= '0;
      flags_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      sop       <= sop_n;
      result    <= result_n;
      flags_q   <= flags_n;
      out_valid <= out_valid_n;
    end
  end

  assign zf = flags_q.zf;
  assign cf = flags_q.cf;
  assign vf = flags_q.vf;
  assign sf = flags_q.sf;

endmodule
